// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button debouncing, run/lap/pause/done sequencing of a
// two-digit BCD counter, lap snapshot and live/lap display mux.

// Two-FF synchronizer plus stable-sample debouncer; emits a one-cycle pulse
// on each accepted rising level. Release edges are accepted but not pulsed.
module stopwatch_deb #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          level_dly_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count consecutive samples that disagree with the accepted level; flip once enough
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES)) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounce state and delayed level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  assign pulse = level_q & ~level_dly_q;

endmodule

module stopwatch_ctrl #(
  parameter int          DEB_CYCLES = 16,
  parameter logic [3:0]  MAX_TENS   = 4'd9,
  parameter logic [3:0]  MAX_ONES   = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic [3:0] cnt_tens,
  input  logic [3:0] cnt_ones,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       running,
  output logic       done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_LAP   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  logic       start_p;
  logic       lap_p;
  logic       at_max;
  logic       counting;

  state_t     state_q,     state_d;
  logic [3:0] lap_tens_q,  lap_tens_d;
  logic [3:0] lap_ones_q,  lap_ones_d;
  logic       cnt_en_q,    cnt_en_d;
  logic       cnt_clr_q,   cnt_clr_d;
  logic       running_q,   running_d;
  logic       done_q,      done_d;

  stopwatch_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_start),
    .pulse   (start_p)
  );

  stopwatch_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_lap),
    .pulse   (lap_p)
  );

  // Illegal BCD digits count as terminal so a corrupted counter stops instead of wrapping
  assign at_max = ((cnt_tens == MAX_TENS) && (cnt_ones == MAX_ONES))
                  || (cnt_tens > 4'd9) || (cnt_ones > 4'd9);

  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);

  // Next state, lap capture and registered output values
  always_comb begin
    state_d    = state_q;
    lap_tens_d = lap_tens_q;
    lap_ones_d = lap_ones_q;
    case (state_q)
      ST_IDLE: begin
        if (start_p) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (at_max) begin
          state_d = ST_DONE;
        end else if (start_p) begin
          state_d = ST_PAUSE;
        end else if (lap_p) begin
          state_d    = ST_LAP;
          lap_tens_d = cnt_tens;
          lap_ones_d = cnt_ones;
        end
      end
      ST_LAP: begin
        if (at_max)       state_d = ST_DONE;
        else if (start_p) state_d = ST_PAUSE;
        else if (lap_p)   state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (start_p)    state_d = ST_RUN;
        else if (lap_p) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (lap_p) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Increment decision uses the state in force when the tick arrives
    cnt_en_d  = tick && counting && !at_max;
    cnt_clr_d = (state_d == ST_IDLE);
    running_d = (state_d == ST_RUN) || (state_d == ST_LAP);
    done_d    = (state_d == ST_DONE);
  end

  // FSM state, lap snapshot and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lap_tens_q <= 4'd0;
      lap_ones_q <= 4'd0;
      cnt_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lap_tens_q <= lap_tens_d;
      lap_ones_q <= lap_ones_d;
      cnt_en_q   <= cnt_en_d;
      cnt_clr_q  <= cnt_clr_d;
      running_q  <= running_d;
      done_q     <= done_d;
    end
  end

  assign disp_tens = (state_q == ST_LAP) ? lap_tens_q : cnt_tens;
  assign disp_ones = (state_q == ST_LAP) ? lap_ones_q : cnt_ones;
  assign cnt_en    = cnt_en_q;
  assign cnt_clr   = cnt_clr_q;
  assign running   = running_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a behavioural BCD counter attached.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic [3:0] cnt_tens;
  logic [3:0] cnt_ones;
  logic       cnt_en;
  logic       cnt_clr;
  logic [3:0] disp_tens;
  logic [3:0] disp_ones;
  logic       running;
  logic       done;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;
  int en0;

  logic [3:0] ct = 4'd0;
  logic [3:0] co = 4'd0;

  stopwatch_ctrl #(.DEB_CYCLES(4), .MAX_TENS(4'd9), .MAX_ONES(4'd9)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .cnt_tens  (cnt_tens),
    .cnt_ones  (cnt_ones),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .disp_tens (disp_tens),
    .disp_ones (disp_ones),
    .running   (running),
    .done      (done),
    .state     (state)
  );

  always #5 clk = ~clk;

  // counter datapath the controller drives
  always_ff @(posedge clk) begin
    if (cnt_clr) begin
      ct <= 4'd0;
      co <= 4'd0;
    end else if (cnt_en) begin
      if (co == 4'd9) begin
        co <= 4'd0;
        ct <= ct + 4'd1;
      end else begin
        co <= co + 4'd1;
      end
    end
  end
  assign cnt_tens = ct;
  assign cnt_ones = co;

  always @(negedge clk) if (cnt_en) en_cnt <= en_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(9);
    end
  endtask

  task automatic press(input logic s, input logic l);
    btn_start = s;
    btn_lap   = l;
    cyc(12);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    cyc(12);
  endtask

  initial begin
    cyc(3);
    chk("rst_state", state, 3'd0);
    chk("rst_clr", cnt_clr, 1'b1);
    chk("rst_en", cnt_en, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    cyc(2);
    chk("idle_disp", {disp_tens, disp_ones}, 8'h00);
    chk("idle_state", state, 3'd0);

    // start latency: RUN exactly 7 cycles after the first sampled edge
    btn_start = 1'b1;
    cyc(7);
    chk("lat_before", state, 3'd0);
    cyc(1);
    chk("lat_run", state, 3'd1);
    chk("lat_running", running, 1'b1);
    cyc(5);
    btn_start = 1'b0;
    cyc(12);
    chk("release_no_pulse", state, 3'd1);
    press(1'b1, 1'b0);
    chk("run_to_pause", state, 3'd3);
    press(1'b0, 1'b1);
    chk("pause_lap_idle", state, 3'd0);

    // bounce rejection
    for (int i = 0; i < 10; i++) begin
      btn_start = ~btn_start;
      cyc(2);
    end
    cyc(12);
    chk("bounce_low", state, 3'd0);
    for (int i = 0; i < 10; i++) begin
      btn_start = ~btn_start;
      cyc(2);
    end
    btn_start = 1'b1;
    cyc(10);
    btn_start = 1'b0;
    cyc(12);
    chk("bounce_high_one_pulse", state, 3'd1);

    // run / pause / resume
    tick_n(15);
    chk("run15", {disp_tens, disp_ones}, 8'h15);
    press(1'b1, 1'b0);
    chk("pause_state", state, 3'd3);
    chk("pause_running", running, 1'b0);
    en0 = en_cnt;
    tick_n(3);
    chk("pause_no_en", en_cnt - en0, 0);
    chk("pause_disp", {disp_tens, disp_ones}, 8'h15);
    press(1'b1, 1'b0);
    chk("resume_state", state, 3'd1);
    tick_n(1);
    chk("resume16", {disp_tens, disp_ones}, 8'h16);
    tick_n(1);
    chk("resume17", {disp_tens, disp_ones}, 8'h17);

    // lap snapshot
    tick_n(6);
    chk("pre_lap23", {disp_tens, disp_ones}, 8'h23);
    press(1'b0, 1'b1);
    chk("lap_state", state, 3'd2);
    chk("lap_running", running, 1'b1);
    tick_n(7);
    chk("lap_disp_held", {disp_tens, disp_ones}, 8'h23);
    chk("lap_live_cnt", {cnt_tens, cnt_ones}, 8'h30);
    press(1'b0, 1'b1);
    chk("lap_release", state, 3'd1);
    chk("lap_release_disp", {disp_tens, disp_ones}, 8'h30);

    // simultaneous buttons: start wins
    press(1'b1, 1'b1);
    chk("simul_pause", state, 3'd3);
    chk("simul_disp_live", {disp_tens, disp_ones}, 8'h30);
    press(1'b0, 1'b1);
    chk("pause_lap_idle2", state, 3'd0);
    chk("idle_clr", cnt_clr, 1'b1);
    chk("idle_disp00", {disp_tens, disp_ones}, 8'h00);

    // terminal count
    press(1'b1, 1'b0);
    tick_n(99);
    chk("term_state", state, 3'd4);
    chk("term_done", done, 1'b1);
    chk("term_running", running, 1'b0);
    chk("term_disp", {disp_tens, disp_ones}, 8'h99);
    en0 = en_cnt;
    tick_n(5);
    chk("term_no_en", en_cnt - en0, 0);
    chk("term_hold", {disp_tens, disp_ones}, 8'h99);
    press(1'b1, 1'b0);
    chk("done_ignore_start", state, 3'd4);
    press(1'b0, 1'b1);
    chk("done_lap_idle", state, 3'd0);
    chk("done_clr", cnt_clr, 1'b1);
    chk("done_disp00", {disp_tens, disp_ones}, 8'h00);

    // asynchronous reset in the middle of a run
    press(1'b1, 1'b0);
    tick_n(37);
    chk("pre_rst37", {disp_tens, disp_ones}, 8'h37);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk("pre_rst_en", cnt_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_state", state, 3'd0);
    chk("async_clr", cnt_clr, 1'b1);
    chk("async_en", cnt_en, 1'b0);
    chk("async_running", running, 1'b0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    chk("post_rst_disp", {disp_tens, disp_ones}, 8'h00);
    chk("post_rst_state", state, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
